// File: rtl/count_pkg.sv
// Shared definitions for the count input-conditioning stage and the l2 pulse counter.
// State codes are exported both as 2-bit localparams and as an enum type.
package count_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_LOW      = 2'b00;
  localparam logic [STATE_W-1:0] ST_RISE_CHK = 2'b01;
  localparam logic [STATE_W-1:0] ST_HIGH     = 2'b10;
  localparam logic [STATE_W-1:0] ST_FALL_CHK = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_LOW      = ST_LOW,
    S_RISE_CHK = ST_RISE_CHK,
    S_HIGH     = ST_HIGH,
    S_FALL_CHK = ST_FALL_CHK
  } cond_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 3;
  localparam int DEF_LONG_CYCLES     = 100;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous input pins, width-parameterised.
// Async active-high reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/count_conditioner.sv
// Synchronises and debounces the raw count line, producing a clean level,
// single-cycle rise/fall pulses and a once-per-press long_press pulse.
module count_conditioner
  import count_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  localparam int CNT_W          = $clog2(LONG_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_raw,
  output logic       count_out,
  output logic       rise,
  output logic       fall,
  output logic       long_press,
  output logic [1:0] s_out
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 1);

  logic             s2;
  cond_state_t      state, state_n;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic             count_out_n, rise_n, fall_n, long_press_n;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (count_raw),
    .q   (s2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOW;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      count_out  <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_n;
      deb_cnt    <= deb_cnt_n;
      hold_cnt   <= hold_cnt_n;
      count_out  <= count_out_n;
      rise       <= rise_n;
      fall       <= fall_n;
      long_press <= long_press_n;
    end
  end

  always_comb begin
    state_n      = state;
    deb_cnt_n    = deb_cnt;
    hold_cnt_n   = hold_cnt;
    count_out_n  = count_out;
    rise_n       = 1'b0;
    fall_n       = 1'b0;
    long_press_n = 1'b0;

    // Hold time accrues across a pending fall so a bounce cannot delay long_press.
    if (state == S_HIGH || state == S_FALL_CHK) begin
      if (hold_cnt != LONG_MAX) hold_cnt_n = hold_cnt + 1'b1;
      if (hold_cnt == LONG_PRE) long_press_n = 1'b1;
    end

    unique case (state)
      S_LOW: begin
        if (s2) begin
          state_n   = S_RISE_CHK;
          deb_cnt_n = '0;
        end
      end
      S_RISE_CHK: begin
        if (!s2) begin
          state_n = S_LOW;
        end else if (deb_cnt == DEB_LAST) begin
          state_n     = S_HIGH;
          rise_n      = 1'b1;
          count_out_n = 1'b1;
          hold_cnt_n  = '0;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s2) begin
          state_n   = S_FALL_CHK;
          deb_cnt_n = '0;
        end
      end
      S_FALL_CHK: begin
        if (s2) begin
          state_n = S_HIGH;
        end else if (deb_cnt == DEB_LAST) begin
          state_n     = S_LOW;
          fall_n      = 1'b1;
          count_out_n = 1'b0;
          hold_cnt_n  = '0;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = S_LOW;
    endcase
  end

  assign s_out = state;

endmodule

// File: tb/tb_count_conditioner.sv
// Bench for count_conditioner: per-cycle scoreboard against a run-length debounce
// model, plus directed scenario checks on pulse counts and latencies.
module tb_count_conditioner;
  import count_pkg::*;

  localparam int DEB  = 3;
  localparam int LONG = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       count_raw = 1'b0;
  logic       count_out, rise, fall, long_press;
  logic [1:0] s_out;

  int checks = 0;
  int passes = 0;

  // clock/reset block
  always #10 clk = ~clk;

  count_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk        (clk),
    .rst        (rst),
    .count_raw  (count_raw),
    .count_out  (count_out),
    .rise       (rise),
    .fall       (fall),
    .long_press (long_press),
    .s_out      (s_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the level flips once DEB+1 consecutive opposite samples have
  // been seen through a two-cycle input delay; long_press fires LONG edges after rise.
  logic [5:0] exp_q[$];
  logic       pipe[$];
  logic       m_level;
  int         m_run;
  int         m_since;

  always @(posedge clk) begin
    logic seen, r, f, lp;
    if (rst) begin
      m_level = 1'b0;
      m_run   = 0;
      m_since = 0;
      pipe.delete();
      pipe.push_back(1'b0);
      pipe.push_back(1'b0);
      exp_q.push_back(6'b0);
    end else begin
      seen = pipe.pop_front();
      pipe.push_back(count_raw);
      r = 1'b0; f = 1'b0; lp = 1'b0;
      if (m_level) begin
        m_since++;
        if (m_since == LONG) lp = 1'b1;
      end
      if (seen != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB + 1) begin
        m_level = !m_level;
        m_run   = 0;
        m_since = 0;
        r = m_level;
        f = !m_level;
      end
      exp_q.push_back({m_level, r, f, lp, m_level, m_run != 0});
    end
  end

  // monitor: pops one expectation per cycle; reset forces all-zero outputs
  int   n_rise, n_fall, n_long, n_hi;
  logic saw_rchk, saw_fchk;

  always @(negedge clk) begin
    logic [5:0] act, exp;
    act = {count_out, rise, fall, long_press, s_out};
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got no expectation for outputs %0h", act);
    end else begin
      exp = exp_q.pop_front();
      if (rst) exp = 6'b0;
      check("cycle_outputs", act, exp);
    end
    if (rise) n_rise++;
    if (fall) n_fall++;
    if (long_press) n_long++;
    if (count_out) n_hi++;
    if (s_out == ST_RISE_CHK) saw_rchk = 1'b1;
    if (s_out == ST_FALL_CHK) saw_fchk = 1'b1;
  end

  // driver tasks: inputs change 5 ns after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic drive(input logic v, input int n);
    count_raw = v;
    tick(n);
  endtask

  task automatic clear_tally();
    n_rise = 0; n_fall = 0; n_long = 0; n_hi = 0;
    saw_rchk = 1'b0; saw_fchk = 1'b0;
  endtask

  initial begin
    clear_tally();
    // reset held while the pin toggles
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #5 count_raw = 1'($urandom_range(0, 1));
    end
    count_raw = 1'b0;
    rst = 1'b0;
    tick(10);
    check("idle_s_out", s_out, ST_LOW);
    check("idle_count_out", count_out, 0);
    check("reset_no_rise", n_rise, 0);

    // four 5-cycle pulses
    clear_tally();
    count_raw = 1'b1;
    tick(5);
    count_raw = 1'b0;
    check("rise_before_latency", rise, 0);
    tick(1);
    check("rise_latency", rise, 1);
    check("count_out_with_rise", count_out, 1);
    tick(4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 5);
    end
    drive(1'b0, 10);
    check("pulses_rise", n_rise, 4);
    check("pulses_fall", n_fall, 4);
    check("pulses_long", n_long, 0);
    check("pulses_high_cycles", n_hi, 20);

    // 2-cycle glitch
    clear_tally();
    drive(1'b1, 2);
    drive(1'b0, 10);
    check("glitch_visits_rise_chk", saw_rchk, 1);
    check("glitch_rise", n_rise, 0);
    check("glitch_count_out", n_hi, 0);
    check("glitch_s_out", s_out, ST_LOW);

    // 200-cycle hold
    clear_tally();
    drive(1'b1, 200);
    drive(1'b0, 10);
    check("hold_rise", n_rise, 1);
    check("hold_long", n_long, 1);
    check("hold_fall", n_fall, 1);

    // hold with a one-cycle bounce
    clear_tally();
    drive(1'b1, 60);
    drive(1'b0, 1);
    drive(1'b1, 139);
    drive(1'b0, 10);
    check("bounce_visits_fall_chk", saw_fchk, 1);
    check("bounce_fall", n_fall, 1);
    check("bounce_long", n_long, 1);

    // long_press boundaries: fall accepted one edge before, and on, the LONG edge
    clear_tally();
    drive(1'b1, 99);
    drive(1'b0, 10);
    check("hold99_long", n_long, 0);
    clear_tally();
    drive(1'b1, 100);
    drive(1'b0, 10);
    check("hold100_long", n_long, 1);
    check("hold100_fall", n_fall, 1);

    // reset mid-HIGH
    drive(1'b1, 20);
    rst = 1'b1;
    #1;
    check("async_reset_count_out", count_out, 0);
    check("async_reset_s_out", s_out, ST_LOW);
    @(posedge clk);
    #5 rst = 1'b0;
    clear_tally();
    tick(5);
    check("post_reset_no_early_rise", rise, 0);
    tick(1);
    check("post_reset_rise", rise, 1);
    drive(1'b0, 10);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom_range(95, 110));
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b0, 1);
        drive(1'b1, $urandom_range(1, 20));
      end
      drive(1'b0, $urandom_range(1, 12));
    end
    drive(1'b0, 12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
